mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Pipeline MEM stage. Sits between the EX/MEM boundary and the MEM/WB register, and is the sole driver of the data memory port.
- The data memory is byte-addressed. It reads a 16-bit word {mem[a+1],mem[a]} combinationally and writes both bytes on the clock edge when write-enable is high.
- The stage performs word and byte loads and stores, plus ALU pass-through. Byte stores use a 2-cycle read-modify-write.
- Load results and ALU results go into a registered output slot with a valid/ready handshake.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 16, data width; byte ops act on bits [7:0].
- REG_AW, 3, destination register index width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  EX stage presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_load  in  1  instruction is a load.
- in_store  in  1  instruction is a store; has priority over in_load.
- in_byte  in  1  byte access (otherwise word).
- in_signed  in  1  sign-extend a byte load.
- in_addr  in  ADDR_W  effective address.
- in_wdata  in  DATA_W  store data.
- in_alu  in  DATA_W  ALU result for non-memory instructions.
- in_rd  in  REG_AW  destination register.
- in_regwrite  in  1  instruction writes a register.
- mem_addr  out  ADDR_W  to memory addr.
- mem_wdata  out  DATA_W  to memory data_in.
- mem_we  out  1  to memory we.
- mem_rdata  in  DATA_W  from memory data_out (combinational).
- out_valid  out  1  MEM/WB slot holds a result.
- out_ready  in  1  WB consumes the slot this cycle.
- out_rd  out  REG_AW  registered destination register.
- out_data  out  DATA_W  registered result.
- out_regwrite  out  1  registered write enable.

Behaviour:
- FSM states: IDLE, RMW.
- slot_free = !out_valid | out_ready.
- In IDLE, in_ready depends on the instruction type:
  - store: in_ready = 1.
  - otherwise: in_ready = slot_free.
- In RMW, in_ready = 0.
- Accept = in_valid & in_ready.
- Word store, accepted in IDLE:
  - mem_addr=in_addr, mem_wdata=in_wdata, mem_we=1 in the same cycle.
  - No output entry.
  - Stay in IDLE.
- Byte store, accepted in IDLE:
  - mem_we=0; mem_addr=in_addr.
  - Latch addr, in_wdata[7:0] and mem_rdata[15:8].
  - Go to RMW.
- RMW, exactly one cycle:
  - mem_addr=latched addr, mem_wdata={latched_hi, latched_byte}, mem_we=1.
  - No output entry.
  - Return to IDLE.
- Load, accepted:
  - mem_addr=in_addr.
  - Word load: out_data <= mem_rdata.
  - Byte load: out_data <= {8{in_signed & mem_rdata[7]}, mem_rdata[7:0]}.
  - Latency 1 cycle to out_valid.
- Non-memory instruction, accepted: out_data <= in_alu; latency 1 cycle.
- Loads and non-memory instructions set out_valid<=1, out_rd<=in_rd, out_regwrite<=in_regwrite.
- When out_ready=1 and nothing new is pushed, out_valid<=0.
- Push and pop in the same cycle: the new entry replaces the old one; out_valid stays 1.
- mem_we is 0 whenever rst=1 and whenever in_valid=0 in IDLE. Each store writes memory exactly once.
- in_load and in_store both set: treated as a store.
- Address wrap-around: byte addr+1 at 0xFFFF is handled by the memory. The stage imposes no alignment rule.
- Reset, including mid-RMW:
  - state<=IDLE and the pending write is dropped; mem_we=0 in the reset cycle.
  - out_valid=0, out_rd=0, out_data=0, out_regwrite=0.
  - Latched RMW registers cleared to 0.

Decomposition:
- Package mem_stage_pkg holds:
  - the state enum (IDLE, RMW);
  - the ADDR_W, DATA_W and REG_AW defaults;
  - a BYTE_W=8 constant.
- Sub-module load_align is combinational: word/byte select and sign/zero extend.
- The FSM and the output slot stay in the top module.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 and in_store=1 -> mem_we=0 throughout; out_valid=0; out_data=0x0000.
- Word store addr=0x0010, wdata=0xBEEF -> mem_we=1 for exactly 1 cycle and in_ready=1. Then word load 0x0010, rd=3 -> next cycle out_valid=1, out_rd=3, out_data=0xBEEF.
- Byte store addr=0x0011, wdata=0x1242 -> in_ready=0 during the RMW cycle; mem_we=1 only in the RMW cycle with mem_wdata=0x0042 (mem[0x12]=0x00 preserved). Then word load 0x0010 -> 0x42EF.
- Byte load 0x0010 with mem[0x10]=0xEF:
  - in_signed=1 -> out_data=0xFFEF.
  - in_signed=0 -> out_data=0x00EF.
- Backpressure: with out_valid=1, set out_ready=0.
  - ALU op (alu=0x1234) -> in_ready=0 and the slot is unchanged.
  - A concurrent word store is still accepted with mem_we=1.
  - Raise out_ready -> the ALU op is accepted the same cycle and out_data=0x1234 next cycle.
- Reset during RMW: assert rst in the RMW cycle of a byte store to 0x0020 -> mem_we=0 and state=IDLE; a later word load of 0x0020 returns the original word.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and default widths for the MEM pipeline stage.
package mem_stage_pkg;

   localparam int ADDR_W_DFLT = 16;
   localparam int DATA_W_DFLT = 16;
   localparam int REG_AW_DFLT = 3;
   localparam int BYTE_W      = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RMW  = 1'b1
   } mem_state_e;

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load data formatting: word pass-through or low byte with sign/zero extension.
module load_align
   import mem_stage_pkg::*;
#(
   parameter int DATA_W = DATA_W_DFLT
) (
   input  logic [DATA_W-1:0] rdata_i,
   input  logic              byte_i,
   input  logic              signed_i,
   output logic [DATA_W-1:0] data_o
);

   logic ext_bit;

   always_comb begin
      ext_bit = signed_i & rdata_i[BYTE_W-1];
      if (byte_i) begin
         data_o = {{(DATA_W-BYTE_W){ext_bit}}, rdata_i[BYTE_W-1:0]};
      end else begin
         data_o = rdata_i;
      end
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: drives the data memory port (byte stores via 2-cycle RMW) and
// holds load/ALU results in a single valid/ready output slot.
module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DFLT,
   parameter int DATA_W = DATA_W_DFLT,
   parameter int REG_AW = REG_AW_DFLT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_load,
   input  logic              in_store,
   input  logic              in_byte,
   input  logic              in_signed,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_wdata,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [REG_AW-1:0] in_rd,
   input  logic              in_regwrite,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [REG_AW-1:0] out_rd,
   output logic [DATA_W-1:0] out_data,
   output logic              out_regwrite
);

   mem_state_e               state_q, state_d;
   logic [ADDR_W-1:0]        rmw_addr_q, rmw_addr_d;
   logic [BYTE_W-1:0]        rmw_byte_q, rmw_byte_d;
   logic [DATA_W-BYTE_W-1:0] rmw_hi_q, rmw_hi_d;

   logic              valid_q;
   logic [REG_AW-1:0] rd_q;
   logic [DATA_W-1:0] data_q;
   logic              regwrite_q;

   logic              slot_free;
   logic              accept;
   logic              push;
   logic [DATA_W-1:0] load_data;
   logic [DATA_W-1:0] push_data;

   assign slot_free = !valid_q | out_ready;

   load_align #(.DATA_W(DATA_W)) u_align (
      .rdata_i  (mem_rdata),
      .byte_i   (in_byte),
      .signed_i (in_signed),
      .data_o   (load_data)
   );

   assign push_data = in_load ? load_data : in_alu;

   always_comb begin
      state_d    = state_q;
      rmw_addr_d = rmw_addr_q;
      rmw_byte_d = rmw_byte_q;
      rmw_hi_d   = rmw_hi_q;
      in_ready   = 1'b0;
      accept     = 1'b0;
      push       = 1'b0;
      mem_addr   = in_addr;
      mem_wdata  = in_wdata;
      mem_we     = 1'b0;

      case (state_q)
         IDLE: begin
            // Stores never touch the output slot, so they bypass backpressure.
            in_ready = in_store ? 1'b1 : slot_free;
            accept   = in_valid & in_ready;
            if (accept) begin
               if (in_store) begin
                  if (in_byte) begin
                     rmw_addr_d = in_addr;
                     rmw_byte_d = in_wdata[BYTE_W-1:0];
                     rmw_hi_d   = mem_rdata[DATA_W-1:BYTE_W];
                     state_d    = RMW;
                  end else begin
                     mem_we = 1'b1;
                  end
               end else begin
                  push = 1'b1;
               end
            end
         end
         RMW: begin
            mem_addr  = rmw_addr_q;
            mem_wdata = {rmw_hi_q, rmw_byte_q};
            mem_we    = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A reset landing mid-RMW must drop the pending write.
      if (rst) begin
         mem_we = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rmw_addr_q <= '0;
         rmw_byte_q <= '0;
         rmw_hi_q   <= '0;
      end else begin
         state_q    <= state_d;
         rmw_addr_q <= rmw_addr_d;
         rmw_byte_q <= rmw_byte_d;
         rmw_hi_q   <= rmw_hi_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= 1'b0;
         rd_q       <= '0;
         data_q     <= '0;
         regwrite_q <= 1'b0;
      end else if (push) begin
         valid_q    <= 1'b1;
         rd_q       <= in_rd;
         data_q     <= push_data;
         regwrite_q <= in_regwrite;
      end else if (out_ready) begin
         valid_q    <= 1'b0;
      end
   end

   assign out_valid    = valid_q;
   assign out_rd       = rd_q;
   assign out_data     = data_q;
   assign out_regwrite = regwrite_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a byte-addressed memory model.
module tb_mem_access_stage;

   logic        gclk;
   logic        rst;
   logic        in_valid, in_ready, in_load, in_store, in_byte, in_signed;
   logic [15:0] in_addr, in_wdata, in_alu;
   logic [2:0]  in_rd;
   logic        in_regwrite;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we;
   logic        out_valid, out_ready, out_regwrite;
   logic [2:0]  out_rd;
   logic [15:0] out_data;

   int nvec = 0;
   int nerr = 0;

   logic [7:0]  mem [0:65535];
   logic [15:0] addr_p1;

   assign addr_p1   = mem_addr + 16'd1;
   assign mem_rdata = {mem[addr_p1], mem[mem_addr]};

   always @(posedge gclk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata[7:0];
         mem[addr_p1]  <= mem_wdata[15:8];
      end
   end

   mem_access_stage dut (
      .clk          (gclk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_load      (in_load),
      .in_store     (in_store),
      .in_byte      (in_byte),
      .in_signed    (in_signed),
      .in_addr      (in_addr),
      .in_wdata     (in_wdata),
      .in_alu       (in_alu),
      .in_rd        (in_rd),
      .in_regwrite  (in_regwrite),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_we       (mem_we),
      .mem_rdata    (mem_rdata),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_rd       (out_rd),
      .out_data     (out_data),
      .out_regwrite (out_regwrite)
   );

   initial gclk = 1'b0;
   always #5 gclk = ~gclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
      end
   endtask

   // Drive an instruction at the falling edge, leaving 1ns for comb settle.
   task automatic drive(input logic v, input logic ld, input logic st, input logic by,
                        input logic sg, input logic [15:0] a, input logic [15:0] wd,
                        input logic [15:0] alu, input logic [2:0] rd);
      @(negedge gclk);
      in_valid = v; in_load = ld; in_store = st; in_byte = by; in_signed = sg;
      in_addr = a; in_wdata = wd; in_alu = alu; in_rd = rd; in_regwrite = 1'b1;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0);
   endtask

   task automatic post();
      @(posedge gclk);
      #1;
   endtask

   initial begin
      rst = 1'b1; out_ready = 1'b1;
      in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_byte = 1'b0; in_signed = 1'b0;
      in_addr = '0; in_wdata = '0; in_alu = '0; in_rd = '0; in_regwrite = 1'b0;

      // reset with a store presented
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'hDEAD, 16'h0, 3'd0);
      chk("rst_we0", {31'b0, mem_we}, 32'h0);
      post();
      #1;
      chk("rst_we1", {31'b0, mem_we}, 32'h0);
      chk("rst_ovalid", {31'b0, out_valid}, 32'h0);
      chk("rst_odata", {16'b0, out_data}, 32'h0);
      @(negedge gclk);
      rst = 1'b0;

      // preload mem[0x12..0x13]=0 and mem[0x20..0x21]=0x1234
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0012, 16'h0000, 16'h0, 3'd0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h1234, 16'h0, 3'd0);

      // word store then word load
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 16'h0, 3'd0);
      chk("wst_rdy", {31'b0, in_ready}, 32'h1);
      chk("wst_we", {31'b0, mem_we}, 32'h1);
      idle();
      chk("wst_we_once", {31'b0, mem_we}, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0, 16'h0, 3'd3);
      chk("wld_rdy", {31'b0, in_ready}, 32'h1);
      post();
      chk("wld_valid", {31'b0, out_valid}, 32'h1);
      chk("wld_rd", {29'b0, out_rd}, 32'd3);
      chk("wld_data", {16'b0, out_data}, 32'hBEEF);

      // byte store via RMW
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0011, 16'h1242, 16'h0, 3'd0);
      chk("bst_rdy", {31'b0, in_ready}, 32'h1);
      chk("bst_we_first", {31'b0, mem_we}, 32'h0);
      idle();
      chk("rmw_rdy", {31'b0, in_ready}, 32'h0);
      chk("rmw_we", {31'b0, mem_we}, 32'h1);
      chk("rmw_addr", {16'b0, mem_addr}, 32'h0011);
      chk("rmw_wdata", {16'b0, mem_wdata}, 32'h0042);
      idle();
      chk("rmw_we_once", {31'b0, mem_we}, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0, 16'h0, 3'd1);
      post();
      chk("rmw_readback", {16'b0, out_data}, 32'h42EF);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0012, 16'h0, 16'h0, 3'd1);
      post();
      chk("rmw_hi_kept", {16'b0, out_data}, 32'h0000);

      // byte loads
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h0, 16'h0, 3'd2);
      post();
      chk("bld_signed", {16'b0, out_data}, 32'hFFEF);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0, 16'h0, 3'd2);
      post();
      chk("bld_unsigned", {16'b0, out_data}, 32'h00EF);

      // backpressure: slot holds 0x00EF
      out_ready = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h1234, 3'd5);
      chk("bp_rdy", {31'b0, in_ready}, 32'h0);
      post();
      chk("bp_hold_valid", {31'b0, out_valid}, 32'h1);
      chk("bp_hold_data", {16'b0, out_data}, 32'h00EF);
      // store with load also set: store wins, bypasses backpressure
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0030, 16'hA5A5, 16'h0, 3'd6);
      chk("bp_st_rdy", {31'b0, in_ready}, 32'h1);
      chk("bp_st_we", {31'b0, mem_we}, 32'h1);
      post();
      chk("bp_st_nopush", {29'b0, out_rd}, 32'd2);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h1234, 3'd5);
      out_ready = 1'b1;
      #1;
      chk("bp_release_rdy", {31'b0, in_ready}, 32'h1);
      post();
      chk("bp_alu_data", {16'b0, out_data}, 32'h1234);
      chk("bp_alu_rd", {29'b0, out_rd}, 32'd5);
      chk("bp_alu_valid", {31'b0, out_valid}, 32'h1);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0030, 16'h0, 16'h0, 3'd4);
      post();
      chk("bp_st_readback", {16'b0, out_data}, 32'hA5A5);
      idle();
      post();
      chk("pop_empty", {31'b0, out_valid}, 32'h0);

      // reset during RMW drops the write
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h0077, 16'h0, 3'd0);
      idle();
      rst = 1'b1;
      #1;
      chk("rstrmw_we", {31'b0, mem_we}, 32'h0);
      post();
      chk("rstrmw_ovalid", {31'b0, out_valid}, 32'h0);
      @(negedge gclk);
      rst = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0, 16'h0, 3'd7);
      chk("rstrmw_idle", {31'b0, in_ready}, 32'h1);
      chk("rstrmw_nowe", {31'b0, mem_we}, 32'h0);
      post();
      chk("rstrmw_orig", {16'b0, out_data}, 32'h1234);
      chk("rstrmw_rd", {29'b0, out_rd}, 32'd7);
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
